// File: rtl/iir_deemph.sv
// Single-pole IIR de-emphasis: y[n] = B0*x[n] + B1*x[n-1] + A1*y[n-1],
// evaluated with one shared multiplier over three MAC cycles per sample.
module iir_deemph #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10,
  parameter logic signed [DATA_WIDTH-1:0] B0 = 178,
  parameter logic signed [DATA_WIDTH-1:0] B1 = 178,
  parameter logic signed [DATA_WIDTH-1:0] A1 = 668
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // out_valid/out_data hold until accepted, in_ready depends only on state.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] DEQ_BIAS =
    {{(PW-QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};
  localparam logic signed [PW-1:0] ZERO_W = '0;

  logic [1:0]                   state;
  logic [1:0]                   tap;
  logic signed [DATA_WIDTH-1:0] x_reg;
  logic signed [DATA_WIDTH-1:0] x_prev;
  logic signed [DATA_WIDTH-1:0] y_prev;
  logic signed [DATA_WIDTH-1:0] acc;

  logic signed [DATA_WIDTH-1:0] coef;
  logic signed [DATA_WIDTH-1:0] operand;
  logic signed [PW-1:0]         coef_w;
  logic signed [PW-1:0]         operand_w;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         bias;
  logic signed [DATA_WIDTH-1:0] deq_val;
  logic signed [DATA_WIDTH-1:0] acc_next;

  always_comb begin
    coef    = B0;
    operand = x_reg;
    case (tap)
      2'd1: begin
        coef    = B1;
        operand = x_prev;
      end
      2'd2: begin
        coef    = A1;
        operand = y_prev;
      end
      default: begin
        coef    = B0;
        operand = x_reg;
      end
    endcase
  end

  assign coef_w    = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef};
  assign operand_w = {{DATA_WIDTH{operand[DATA_WIDTH-1]}}, operand};
  assign prod      = coef_w * operand_w;

  // Adding 2^Q-1 to negative products before the arithmetic shift turns
  // floor division into division truncating toward zero.
  always_comb begin
    bias = ZERO_W;
    if (prod[PW-1]) begin
      bias = DEQ_BIAS;
    end
  end

  assign deq_val  = DATA_WIDTH'((prod + bias) >>> QUANT_BITS);
  assign acc_next = acc + deq_val;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign out_data  = acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      tap    <= 2'd0;
      x_reg  <= '0;
      x_prev <= '0;
      y_prev <= '0;
      acc    <= '0;
    end else if (clear) begin
      state  <= ST_IDLE;
      tap    <= 2'd0;
      x_prev <= '0;
      y_prev <= '0;
      acc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg <= in_data;
            acc   <= '0;
            tap   <= 2'd0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_next;
          if (tap == 2'd2) begin
            tap   <= 2'd0;
            state <= ST_OUT;
          end else begin
            tap <= tap + 2'd1;
          end
        end
        ST_OUT: begin
          // History advances only when the result is actually consumed.
          if (out_ready) begin
            x_prev <= x_reg;
            y_prev <= acc;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          tap   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Directed and randomized checks of iir_deemph against a plain-arithmetic
// model of the difference equation with truncating dequantization.
module tb_iir_deemph;

  localparam int  DW = 32;
  localparam longint C_B0 = 178;
  localparam longint C_B1 = 178;
  localparam longint C_A1 = 668;

  logic          clock;
  logic          reset;
  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int pass_cnt = 0;
  int total    = 0;

  logic [DW-1:0] m_xp;
  logic [DW-1:0] m_yp;
  logic [DW-1:0] obs_y;

  iir_deemph dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic logic [DW-1:0] deq_m(input longint c, input logic [DW-1:0] v);
    longint p;
    p = c * longint'($signed(v));
    return DW'(p / 1024);
  endfunction

  function automatic logic [DW-1:0] model_y(input logic [DW-1:0] x);
    return deq_m(C_B0, x) + deq_m(C_B1, m_xp) + deq_m(C_A1, m_yp);
  endfunction

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_xp = '0;
    m_yp = '0;
  endtask

  // Presents x in IDLE and returns just after the accept edge (cycle 0).
  task automatic start_accept(input logic [DW-1:0] x);
    @(negedge clock);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic run_txn(input logic [DW-1:0] x, input int stall, output logic [DW-1:0] y);
    logic [DW-1:0] exp;
    exp = model_y(x);
    start_accept(x);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("out_valid_low_in_mac", {31'd0, out_valid}, 32'd0);
      check("in_ready_low_in_mac", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock);
    check("out_valid_cycle4", {31'd0, out_valid}, 32'd1);
    check("in_ready_low_cycle4", {31'd0, in_ready}, 32'd0);
    check("out_data", out_data, exp);
    y = out_data;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge clock);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_data", out_data, exp);
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = $urandom;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    m_xp = x;
    m_yp = exp;
    @(negedge clock);
    check("idle_after_accept_valid", {31'd0, out_valid}, 32'd0);
    check("idle_after_accept_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] x;
    m_xp = '0;
    m_yp = '0;
    do_reset();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_data", out_data, 32'd0);

    run_txn(32'd1024, 0, obs_y);
    check("impulse_first", obs_y, 32'd178);
    run_txn(32'd1024, 0, obs_y);
    check("impulse_second", obs_y, 32'd472);

    do_reset();
    run_txn(-32'sd1024, 0, obs_y);
    check("neg_first", obs_y, -32'sd178);
    run_txn(32'd0, 0, obs_y);
    check("neg_trunc_zero", obs_y, -32'sd294);

    do_reset();
    run_txn(-32'sd1, 0, obs_y);
    check("minus_one_trunc", obs_y, 32'd0);

    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) x = $urandom;
      else x = DW'($urandom_range(0, 8000)) - 32'd4000;
      run_txn(x, $urandom_range(0, 3), obs_y);
    end

    run_txn(DW'($urandom_range(0, 5000)), 20, obs_y);
    run_txn(DW'($urandom_range(0, 5000)), 0, obs_y);

    // clear during MAC discards the sample and all history
    start_accept(32'd3000);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("clear_mac_out_valid", {31'd0, out_valid}, 32'd0);
    check("clear_mac_in_ready", {31'd0, in_ready}, 32'd1);
    m_xp = '0;
    m_yp = '0;
    run_txn(32'd1024, 0, obs_y);
    check("after_clear_mac", obs_y, 32'd178);

    // clear beats a simultaneous accept in IDLE
    @(negedge clock);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd5;
    @(posedge clock);
    #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("clear_beats_in_valid", {31'd0, in_ready}, 32'd1);
    m_xp = '0;
    m_yp = '0;

    // clear beats a simultaneous out_ready in OUT
    run_txn(32'd1024, 0, obs_y);
    start_accept(32'd1024);
    repeat (4) @(negedge clock);
    check("pre_clear_out_valid", {31'd0, out_valid}, 32'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("clear_out_valid", {31'd0, out_valid}, 32'd0);
    check("clear_out_in_ready", {31'd0, in_ready}, 32'd1);
    m_xp = '0;
    m_yp = '0;
    run_txn(32'd1024, 0, obs_y);
    check("after_clear_out", obs_y, 32'd178);

    // asynchronous reset mid-MAC takes effect without a clock edge
    run_txn(32'd2048, 0, obs_y);
    start_accept(32'd1024);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_reset_out_data", out_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    m_xp = '0;
    m_yp = '0;
    run_txn(32'd1024, 0, obs_y);
    check("after_async_reset", obs_y, 32'd178);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
